operand_entry: RTL

- Sequential front end of the calculator: captures two 4-bit operands from the slide switches using a debounced ENTER pushbutton.
- Presents the captured operands as stable registered buses to the downstream ripple adder, which feeds the seven-segment display stage.
- Replaces direct switch wiring, so both operands share one switch bank and the adder inputs do not glitch while the switches move.

---
 rtl/calc_pkg.sv | 12 +
 rtl/button_debounce.sv | 53 +++++
 rtl/operand_entry.sv | 97 +++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand-entry state encoding and default operand width.
package calc_pkg;

    localparam int OPERAND_WIDTH = 4;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        SHOW   = 2'b10
    } state_e;

endpackage

// File: rtl/button_debounce.sv
// Active-low pushbutton conditioning: 2-flop synchroniser, level debounce and
// a one-cycle pulse on each accepted press (accepted level 1 -> 0).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic pulse_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Released (1) is the idle level, so reset must not look like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_n_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_prev_q & ~level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/operand_entry.sv
// Two-operand entry front end: ENTER captures SW into A then B, CLEAR restarts;
// operands are held in registers so the adder never sees switch movement.
module operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH           = OPERAND_WIDTH,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW,
    input  logic             ENTER_N,
    input  logic             CLEAR_N,
    output logic [WIDTH-1:0] OPA,
    output logic [WIDTH-1:0] OPB,
    output logic             RESULT_VALID,
    output logic [1:0]       STATE_LED
);
    logic             enter_pulse, clear_pulse;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic             valid_q, valid_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .btn_n_i (ENTER_N),
        .pulse_o (enter_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .btn_n_i (CLEAR_N),
        .pulse_o (clear_pulse)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= WAIT_A;
            opa_q   <= '0;
            opb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            valid_q <= valid_d;
        end
    end

    // Clear is checked first so a coincident enter is dropped.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        valid_d = valid_q;
        if (clear_pulse) begin
            state_d = WAIT_A;
            opa_d   = '0;
            opb_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (enter_pulse) begin
                    opa_d   = SW;
                    state_d = WAIT_B;
                end
                WAIT_B: if (enter_pulse) begin
                    opb_d   = SW;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
                SHOW: if (enter_pulse) begin
                    opa_d   = SW;
                    opb_d   = '0;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
                default: begin
                    state_d = WAIT_A;
                    opa_d   = '0;
                    opb_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        OPA          = opa_q;
        OPB          = opb_q;
        RESULT_VALID = valid_q;
        STATE_LED    = state_q;
    end

endmodule
